// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : MIPS instruction-decode stage. Decodes the fetch instruction,
//               reads the 32-entry register file (with optional same-cycle
//               writeback forwarding), forms immediate, jump and branch
//               targets and the destination register, and launches the
//               bundle into a registered ID/EX stage with a valid/ready
//               handshake. Detects load-use hazards (one bubble each),
//               kills ID/EX on flush and counts hazard bubbles.
// Ports       :
//   clk, rst                 clock, synchronous active-high reset
//   if_valid_i/if_instr_i/if_pc4_i   instruction from fetch
//   id_ready_o               instruction consumed this cycle
//   op_code_o, funct_o       opcode/funct fields to the control unit
//   ctl_*_i                  combinational controls for the current instr
//   flush_i                  kill entering and held instruction
//   wb_we_i/wb_addr_i/wb_data_i  register writeback port
//   ex_ready_i               EX accepts the ID/EX bundle
//   ex_*_o                   registered ID/EX bundle
//   bubble_cnt_o             saturating count of load-use bubbles
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage #(
  parameter int DATA_W   = 32,
  parameter int BYPASS   = 1,
  parameter int HAZARD   = 1,
  parameter int SYS_R1   = 2,
  parameter int SYS_R2   = 4,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  input  logic [31:0]       if_instr_i,
  input  logic [DATA_W-1:0] if_pc4_i,
  output logic              id_ready_o,
  output logic [5:0]        op_code_o,
  output logic [5:0]        funct_o,
  input  logic              ctl_syscall_i,
  input  logic              ctl_regdst_i,
  input  logic              ctl_jal_i,
  input  logic              ctl_signed_ext_i,
  input  logic              ctl_regwrite_i,
  input  logic              ctl_memread_i,
  input  logic              flush_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              ex_ready_i,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [4:0]        ex_shamt_o,
  output logic [4:0]        ex_dst_o,
  output logic              ex_regwrite_o,
  output logic              ex_memread_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic [DATA_W-1:0] ex_addr_jmp_o,
  output logic [DATA_W-1:0] ex_addr_beq_o,
  output logic [31:0]       bubble_cnt_o
);

  localparam logic [4:0] c_sys_r1   = 5'(SYS_R1);
  localparam logic [4:0] c_sys_r2   = 5'(SYS_R2);
  localparam logic [4:0] c_link_reg = 5'(LINK_REG);

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] rf_q [32];
  logic              w_wb_hit;

  assign w_wb_hit = wb_we_i && (wb_addr_i != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (w_wb_hit) begin
      rf_q[wb_addr_i] <= wb_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [4:0]        w_r1;
  logic [4:0]        w_r2;
  logic [DATA_W-1:0] w_rf_r1;
  logic [DATA_W-1:0] w_rf_r2;
  logic [DATA_W-1:0] w_rs;
  logic [DATA_W-1:0] w_rt;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_jmp;
  logic [DATA_W-1:0] w_beq;
  logic [4:0]        w_dst;

  assign op_code_o = if_instr_i[31:26];
  assign funct_o   = if_instr_i[5:0];

  // Syscall reads its argument registers at fixed addresses.
  assign w_r1 = ctl_syscall_i ? c_sys_r1 : if_instr_i[25:21];
  assign w_r2 = ctl_syscall_i ? c_sys_r2 : if_instr_i[20:16];

  // Entry 0 is hardwired to zero regardless of array contents.
  assign w_rf_r1 = (w_r1 == 5'd0) ? '0 : rf_q[w_r1];
  assign w_rf_r2 = (w_r2 == 5'd0) ? '0 : rf_q[w_r2];

  generate
    if (BYPASS != 0) begin : g_bypass
      assign w_rs = (w_wb_hit && (wb_addr_i == w_r1)) ? wb_data_i : w_rf_r1;
      assign w_rt = (w_wb_hit && (wb_addr_i == w_r2)) ? wb_data_i : w_rf_r2;
    end else begin : g_no_bypass
      assign w_rs = w_rf_r1;
      assign w_rt = w_rf_r2;
    end
  endgenerate

  assign w_imm = ctl_signed_ext_i ? {{(DATA_W-16){if_instr_i[15]}}, if_instr_i[15:0]}
                                  : {{(DATA_W-16){1'b0}}, if_instr_i[15:0]};

  assign w_jmp = {{(DATA_W-28){1'b0}}, if_instr_i[25:0], 2'b00};
  assign w_beq = {w_imm[DATA_W-3:0], 2'b00} + if_pc4_i;

  always_comb begin
    w_dst = 5'd0;
    if (ctl_regwrite_i) begin
      if (ctl_jal_i)         w_dst = c_link_reg;
      else if (ctl_regdst_i) w_dst = if_instr_i[15:11];
      else                   w_dst = if_instr_i[20:16];
    end
  end

  // --------------------------------------------------------------------------
  // Handshake and hazard control
  // --------------------------------------------------------------------------
  logic              ex_valid_q;
  logic [DATA_W-1:0] ex_rs_q;
  logic [DATA_W-1:0] ex_rt_q;
  logic [DATA_W-1:0] ex_imm_q;
  logic [4:0]        ex_shamt_q;
  logic [4:0]        ex_dst_q;
  logic              ex_regwrite_q;
  logic              ex_memread_q;
  logic [DATA_W-1:0] ex_pc4_q;
  logic [DATA_W-1:0] ex_jmp_q;
  logic [DATA_W-1:0] ex_beq_q;
  logic [31:0]       bubble_cnt_q;
  logic [31:0]       bubble_cnt_d;
  logic              w_hazard;
  logic              w_adv;

  generate
    if (HAZARD != 0) begin : g_hazard
      // A load in ID/EX whose result is needed by the decoding instruction.
      assign w_hazard = if_valid_i && ex_valid_q && ex_memread_q &&
                        (ex_dst_q != 5'd0) &&
                        ((ex_dst_q == w_r1) || (ex_dst_q == w_r2));
    end else begin : g_no_hazard
      assign w_hazard = 1'b0;
    end
  endgenerate

  assign w_adv      = !ex_valid_q || ex_ready_i;
  assign id_ready_o = flush_i || (w_adv && !w_hazard);

  assign bubble_cnt_d = (bubble_cnt_q == 32'hFFFF_FFFF) ? bubble_cnt_q
                                                        : bubble_cnt_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_imm_q      <= '0;
      ex_shamt_q    <= '0;
      ex_dst_q      <= '0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_pc4_q      <= '0;
      ex_jmp_q      <= '0;
      ex_beq_q      <= '0;
      bubble_cnt_q  <= '0;
    end else if (flush_i) begin
      ex_valid_q <= 1'b0;
    end else if (w_adv) begin
      // Payload loads on bubble/idle cycles too; ex_valid qualifies it.
      ex_valid_q    <= if_valid_i && !w_hazard;
      ex_rs_q       <= w_rs;
      ex_rt_q       <= w_rt;
      ex_imm_q      <= w_imm;
      ex_shamt_q    <= if_instr_i[10:6];
      ex_dst_q      <= w_dst;
      ex_regwrite_q <= ctl_regwrite_i;
      ex_memread_q  <= ctl_memread_i;
      ex_pc4_q      <= if_pc4_i;
      ex_jmp_q      <= w_jmp;
      ex_beq_q      <= w_beq;
      if (w_hazard) begin
        bubble_cnt_q <= bubble_cnt_d;
      end
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_rs_data_o  = ex_rs_q;
  assign ex_rt_data_o  = ex_rt_q;
  assign ex_imm_o      = ex_imm_q;
  assign ex_shamt_o    = ex_shamt_q;
  assign ex_dst_o      = ex_dst_q;
  assign ex_regwrite_o = ex_regwrite_q;
  assign ex_memread_o  = ex_memread_q;
  assign ex_pc4_o      = ex_pc4_q;
  assign ex_addr_jmp_o = ex_jmp_q;
  assign ex_addr_beq_o = ex_beq_q;
  assign bubble_cnt_o  = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage
// Description : Scoreboard bench for id_stage. Expected ID/EX bundles are
//               built from a reference register-file model when an
//               instruction is issued and compared one cycle later.
//               A second instance with BYPASS=0 shares all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

  localparam int DW = 32;

  // control vector bit order: {syscall, regdst, jal, sext, regwrite, memread}
  localparam logic [5:0] c_none  = 6'b000000;
  localparam logic [5:0] c_rtype = 6'b010010;
  localparam logic [5:0] c_addi  = 6'b000110;
  localparam logic [5:0] c_ori   = 6'b000010;
  localparam logic [5:0] c_lw    = 6'b000111;
  localparam logic [5:0] c_jal   = 6'b001010;
  localparam logic [5:0] c_sys   = 6'b100000;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [DW-1:0] if_pc4;
  logic          ctl_syscall, ctl_regdst, ctl_jal, ctl_signed_ext, ctl_regwrite, ctl_memread;
  logic          flush;
  logic          wb_we;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          ex_ready;

  logic          id_ready, ex_valid, ex_regwrite, ex_memread;
  logic [5:0]    op_code, funct;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_addr_jmp, ex_addr_beq;
  logic [4:0]    ex_shamt, ex_dst;
  logic [31:0]   bubble_cnt;

  logic          nb_id_ready, nb_ex_valid, nb_ex_regwrite, nb_ex_memread;
  logic [5:0]    nb_op_code, nb_funct;
  logic [DW-1:0] nb_ex_rs_data, nb_ex_rt_data, nb_ex_imm, nb_ex_pc4, nb_ex_addr_jmp, nb_ex_addr_beq;
  logic [4:0]    nb_ex_shamt, nb_ex_dst;
  logic [31:0]   nb_bubble_cnt;

  always #5 clk = ~clk;

  id_stage #(.DATA_W(DW), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid), .if_instr_i(if_instr), .if_pc4_i(if_pc4),
    .id_ready_o(id_ready), .op_code_o(op_code), .funct_o(funct),
    .ctl_syscall_i(ctl_syscall), .ctl_regdst_i(ctl_regdst), .ctl_jal_i(ctl_jal),
    .ctl_signed_ext_i(ctl_signed_ext), .ctl_regwrite_i(ctl_regwrite), .ctl_memread_i(ctl_memread),
    .flush_i(flush), .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .ex_ready_i(ex_ready), .ex_valid_o(ex_valid),
    .ex_rs_data_o(ex_rs_data), .ex_rt_data_o(ex_rt_data), .ex_imm_o(ex_imm),
    .ex_shamt_o(ex_shamt), .ex_dst_o(ex_dst), .ex_regwrite_o(ex_regwrite),
    .ex_memread_o(ex_memread), .ex_pc4_o(ex_pc4), .ex_addr_jmp_o(ex_addr_jmp),
    .ex_addr_beq_o(ex_addr_beq), .bubble_cnt_o(bubble_cnt)
  );

  id_stage #(.DATA_W(DW), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid), .if_instr_i(if_instr), .if_pc4_i(if_pc4),
    .id_ready_o(nb_id_ready), .op_code_o(nb_op_code), .funct_o(nb_funct),
    .ctl_syscall_i(ctl_syscall), .ctl_regdst_i(ctl_regdst), .ctl_jal_i(ctl_jal),
    .ctl_signed_ext_i(ctl_signed_ext), .ctl_regwrite_i(ctl_regwrite), .ctl_memread_i(ctl_memread),
    .flush_i(flush), .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .ex_ready_i(ex_ready), .ex_valid_o(nb_ex_valid),
    .ex_rs_data_o(nb_ex_rs_data), .ex_rt_data_o(nb_ex_rt_data), .ex_imm_o(nb_ex_imm),
    .ex_shamt_o(nb_ex_shamt), .ex_dst_o(nb_ex_dst), .ex_regwrite_o(nb_ex_regwrite),
    .ex_memread_o(nb_ex_memread), .ex_pc4_o(nb_ex_pc4), .ex_addr_jmp_o(nb_ex_addr_jmp),
    .ex_addr_beq_o(nb_ex_addr_beq), .bubble_cnt_o(nb_bubble_cnt)
  );

  typedef struct {
    logic [31:0] rs, rt, rs_nb, rt_nb, imm, pc4, jmp, beq;
    logic [4:0]  shamt, dst;
    logic        regwrite, memread;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mrf [32];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the reference register file, then compare
  // any bundle issued in the previous cycle.
  task automatic step();
    exp_t e;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mrf[i] = '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      mrf[wb_addr] = wb_data;
    end
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("ex_valid", ex_valid, 1'b1);
      chk("ex_rs_data", ex_rs_data, e.rs);
      chk("ex_rt_data", ex_rt_data, e.rt);
      chk("nb_ex_rs_data", nb_ex_rs_data, e.rs_nb);
      chk("nb_ex_rt_data", nb_ex_rt_data, e.rt_nb);
      chk("ex_imm", ex_imm, e.imm);
      chk("ex_shamt", ex_shamt, e.shamt);
      chk("ex_dst", ex_dst, e.dst);
      chk("ex_regwrite", ex_regwrite, e.regwrite);
      chk("ex_memread", ex_memread, e.memread);
      chk("ex_pc4", ex_pc4, e.pc4);
      chk("ex_addr_jmp", ex_addr_jmp, e.jmp);
      chk("ex_addr_beq", ex_addr_beq, e.beq);
    end
  endtask

  function automatic logic [31:0] rd_byp(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_we && wb_addr == r) return wb_data;
    return mrf[r];
  endfunction

  function automatic logic [31:0] rd_arr(input logic [4:0] r);
    return (r == 5'd0) ? 32'h0 : mrf[r];
  endfunction

  // Present an instruction; check id_ready; optionally queue its bundle.
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc4,
                       input logic [5:0] ctl, input logic exp_rdy, input logic push);
    exp_t       e;
    logic [4:0] r1, r2;
    if_valid = 1'b1;
    if_instr = instr;
    if_pc4   = pc4;
    {ctl_syscall, ctl_regdst, ctl_jal, ctl_signed_ext, ctl_regwrite, ctl_memread} = ctl;
    #1;
    chk("id_ready", id_ready, exp_rdy);
    chk("op_code", op_code, instr[31:26]);
    chk("funct", funct, instr[5:0]);
    if (push) begin
      r1 = ctl[5] ? 5'd2 : instr[25:21];
      r2 = ctl[5] ? 5'd4 : instr[20:16];
      e.rs    = rd_byp(r1);
      e.rt    = rd_byp(r2);
      e.rs_nb = rd_arr(r1);
      e.rt_nb = rd_arr(r2);
      e.imm   = ctl[2] ? {{16{instr[15]}}, instr[15:0]} : {16'h0, instr[15:0]};
      e.pc4   = pc4;
      e.jmp   = {4'h0, instr[25:0], 2'b00};
      e.beq   = (e.imm << 2) + pc4;
      e.shamt = instr[10:6];
      e.regwrite = ctl[1];
      e.memread  = ctl[0];
      if (!ctl[1])     e.dst = 5'd0;
      else if (ctl[3]) e.dst = 5'd31;
      else if (ctl[4]) e.dst = instr[15:11];
      else             e.dst = instr[20:16];
      sb_q.push_back(e);
    end
    step();
  endtask

  task automatic idle();
    if_valid = 1'b0;
    if_instr = 32'h0;
    step();
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    idle();
    wb_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    // Reset with busy inputs: rst must override flush and writeback.
    rst = 1'b1; if_valid = 1'b1; if_instr = 32'h2006FFFC; if_pc4 = 32'h100;
    {ctl_syscall, ctl_regdst, ctl_jal, ctl_signed_ext, ctl_regwrite, ctl_memread} = c_lw;
    flush = 1'b1; wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'hDEAD_BEEF; ex_ready = 1'b1;
    step(); step();
    chk("rst ex_valid", ex_valid, 1'b0);
    chk("rst ex_dst", ex_dst, 5'd0);
    chk("rst ex_imm", ex_imm, 32'h0);
    chk("rst ex_pc4", ex_pc4, 32'h0);
    chk("rst ex_memread", ex_memread, 1'b0);
    chk("rst bubble_cnt", bubble_cnt, 32'h0);
    rst = 1'b0; flush = 1'b0; wb_we = 1'b0;

    // add $3,$1,$2 after reset: operands zero, dst 3.
    drive(32'h00221820, 32'h4, c_rtype, 1'b1, 1'b1);

    // Same-cycle writeback of $1 with a read of $1.
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h12345678;
    drive(32'h00221820, 32'h8, c_rtype, 1'b1, 1'b1);
    wb_we = 1'b0;
    // Now visible from the array in both instances.
    drive(32'h00221820, 32'hC, c_rtype, 1'b1, 1'b1);

    // Syscall operands from $2 and $4.
    wb(5'd2, 32'd10);
    wb(5'd4, 32'h55);
    drive(32'h0000000C, 32'h10, c_sys, 1'b1, 1'b1);

    // Write to $0 is neither forwarded nor stored.
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    drive(32'h00001820, 32'h14, c_rtype, 1'b1, 1'b1);
    wb_we = 1'b0;
    drive(32'h00001820, 32'h18, c_rtype, 1'b1, 1'b1);

    // Immediates and targets.
    drive(32'h2006FFFC, 32'h100, c_addi, 1'b1, 1'b1);
    drive(32'h3406FFFC, 32'h100, c_ori, 1'b1, 1'b1);
    drive(32'h0C000040, 32'h200, c_jal, 1'b1, 1'b1);
    drive(32'h00431140, 32'h204, c_rtype, 1'b1, 1'b1);

    // Load-use on rs: one bubble, then issue.
    drive(32'h8C250000, 32'h300, c_lw, 1'b1, 1'b1);
    drive(32'h00A03020, 32'h304, c_rtype, 1'b0, 1'b0);
    chk("bubble ex_valid", ex_valid, 1'b0);
    chk("bubble_cnt 1", bubble_cnt, 32'd1);
    drive(32'h00A03020, 32'h304, c_rtype, 1'b1, 1'b1);

    // Load-use on rt.
    drive(32'h8C250000, 32'h400, c_lw, 1'b1, 1'b1);
    drive(32'h00053820, 32'h404, c_rtype, 1'b0, 1'b0);
    chk("bubble_cnt 2", bubble_cnt, 32'd2);
    drive(32'h00053820, 32'h404, c_rtype, 1'b1, 1'b1);

    // Load not followed by a use: no bubble.
    drive(32'h8C250000, 32'h500, c_lw, 1'b1, 1'b1);
    drive(32'h00221820, 32'h504, c_rtype, 1'b1, 1'b1);
    chk("no-use bubble_cnt", bubble_cnt, 32'd2);

    // Flush coinciding with a hazard: flush wins, no bubble counted.
    drive(32'h8C250000, 32'h600, c_lw, 1'b1, 1'b1);
    flush = 1'b1;
    drive(32'h00A03020, 32'h604, c_rtype, 1'b1, 1'b0);
    flush = 1'b0;
    chk("flush+haz ex_valid", ex_valid, 1'b0);
    chk("flush+haz bubble_cnt", bubble_cnt, 32'd2);

    // Downstream stall holds the bundle, then flush kills it.
    drive(32'h00221820, 32'h700, c_rtype, 1'b1, 1'b1);
    ex_ready = 1'b0;
    drive(32'h3406FFFC, 32'h704, c_ori, 1'b0, 1'b0);
    chk("stall ex_valid", ex_valid, 1'b1);
    chk("stall ex_dst", ex_dst, 5'd3);
    chk("stall ex_pc4", ex_pc4, 32'h700);
    chk("stall ex_rs_data", ex_rs_data, 32'h12345678);
    flush = 1'b1;
    drive(32'h3406FFFC, 32'h704, c_ori, 1'b1, 1'b0);
    flush = 1'b0; ex_ready = 1'b1;
    chk("stall-flush ex_valid", ex_valid, 1'b0);
    chk("stall-flush bubble_cnt", bubble_cnt, 32'd2);

    // Idle fetch leaves ID/EX empty.
    {ctl_syscall, ctl_regdst, ctl_jal, ctl_signed_ext, ctl_regwrite, ctl_memread} = c_none;
    idle();
    chk("idle ex_valid", ex_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Pipelined instruction-decode stage for the MIPS pipeline core, parametrised in datapath width, with optional writeback bypass, load-use hazard detection and a registered ID/EX output with a valid/ready handshake. It decodes the 32-bit instruction held by fetch and reads the register file, applying writeback-to-read forwarding. It computes jump/branch targets and the destination register, then launches the bundle into EX. It stalls fetch on load-use hazards, kills its output on flush, and counts inserted bubbles.

## Interface
- DATA_W, 32: register/datapath width; must be ≥32. Immediates and addresses are extended to DATA_W.
- BYPASS, 1: 1 = same-cycle writeback data forwarded to reads; 0 = read register array only.
- HAZARD, 1: 1 = load-use detection enabled; 0 = never stall for hazards.
- SYS_R1, 2: rs substitute when ctl_syscall = 1.
- SYS_R2, 4: rt substitute when ctl_syscall = 1.
- LINK_REG, 31: destination for jal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  instruction word.
- if_pc4  in  DATA_W  PC+4 of that instruction.
- id_ready  out  1  stage consumes the fetch instruction this cycle.
- op_code  out  6  if_instr[31:26], to control unit.
- funct  out  6  if_instr[5:0], to control unit.
- ctl_syscall, ctl_regdst, ctl_jal, ctl_signed_ext, ctl_regwrite, ctl_memread  in  1 each  combinational controls for the current instruction.
- flush  in  1  kill instruction entering and held in ID/EX.
- wb_we  in  1  writeback enable.
- wb_addr  in  5  writeback register.
- wb_data  in  DATA_W  writeback data.
- ex_ready  in  1  EX accepts the ID/EX bundle.
- ex_valid  out  1  ID/EX bundle valid.
- ex_rs_data, ex_rt_data  out  DATA_W  operands.
- ex_imm  out  DATA_W  extended immediate.
- ex_shamt  out  5  instr[10:6].
- ex_dst  out  5  destination register; 0 means no write.
- ex_regwrite, ex_memread  out  1  registered controls.
- ex_pc4, ex_addr_jmp, ex_addr_beq  out  DATA_W  PC+4, jump target, branch target.
- bubble_cnt  out  32  saturating count of hazard bubbles.

## Operation
- Register file: 32 × DATA_W. Entry 0 reads 0 and is never written. A write occurs on wb_we & wb_addr≠0 at the clock edge.
- Read addresses: r1 = ctl_syscall ? SYS_R1 : instr[25:21]; r2 = ctl_syscall ? SYS_R2 : instr[20:16].
- Bypass (BYPASS=1): if wb_we & wb_addr≠0 & wb_addr==rN, read data = wb_data.
- Immediate: ctl_signed_ext ? sign-extend instr[15:0] : zero-extend instr[15:0], to DATA_W.
- ex_addr_jmp = zero-extend(instr[25:0]) << 2, truncated to DATA_W.
- ex_addr_beq = (imm << 2) + if_pc4, modulo 2^DATA_W.
- Destination: !ctl_regwrite → 0; else ctl_jal → LINK_REG; else ctl_regdst → instr[15:11]; else instr[20:16].
- hazard = HAZARD & if_valid & ex_valid & ex_memread & ex_dst≠0 & (ex_dst==r1 | ex_dst==r2).
- adv = !ex_valid | ex_ready (ID/EX may load).
- id_ready = flush | (adv & !hazard).
- Next-state priority, highest first:
  - flush: ex_valid ← 0; the fetch instruction is consumed and dropped.
  - adv & hazard: ex_valid ← 0 (bubble); bubble_cnt increments, saturating at 0xFFFFFFFF.
  - adv: ex_valid ← if_valid; the bundle loads when if_valid.
  - otherwise: hold all ex_* outputs.
- Payload registers may load on bubble cycles; consumers use ex_valid.

## Timing
- Reset: all registers, ex_valid, all ex_* outputs and bubble_cnt go to 0 in the cycle after rst is sampled high. rst overrides flush and writeback. During rst, id_ready is combinational and ignored by the pipeline.
- Latency: IF→ID/EX is 1 cycle. A write at edge N is visible in the array from cycle N+1, and in the same cycle via bypass.
- A load-use costs exactly one bubble: the next cycle has ex_valid=0 and the load ex_dst is gone, so hazard clears.
- Downstream stall (ex_valid & !ex_ready): outputs stable, id_ready=0, no bubble counted.
- A write to register 0 is never forwarded or stored.
- Simultaneous flush and hazard: flush wins and no bubble is counted.

## Test plan
- Reset then read: after rst, instr 0x00221820 (add $3,$1,$2) with if_valid → next cycle ex_valid=1, ex_rs_data=0, ex_rt_data=0, ex_dst=3 (regdst, regwrite).
- Bypass: wb_we=1, wb_addr=1, wb_data=0x12345678 in the same cycle as reading $1 → ex_rs_data=0x12345678. With BYPASS=0 → 0.
- Load-use: ID/EX holds lw with ex_dst=5 and memread; ID instr uses rs=5 → id_ready=0, one bubble (ex_valid=0), bubble_cnt=1, then the instruction issues.
- Immediates/targets: imm 0xFFFC, pc4=0x100, signed → ex_imm=0xFFFFFFFC, ex_addr_beq=0xF0. jal with instr[25:0]=0x40 → ex_addr_jmp=0x100, ex_dst=31.
- Syscall and $0: ctl_syscall=1 with $2=10, $4=0x55 → operands 10 and 0x55. A write to $0 of 0xFFFF leaves $0 reading 0.
- Flush during downstream stall: ex_valid=1, ex_ready=0, flush=1 → id_ready=1, next cycle ex_valid=0, bubble_cnt unchanged.
